divisor_secuencial_nbit: RTL and testbench
==========================================

// Module: divisor_secuencial_nbit
// PURPOSE
//  Multi-cycle restoring radix-2 divider, successor to the combinational N-bit divider.
//  Produces one quotient bit per clock, so wide N does not cost a long combinational path.
//  Supports unsigned and signed (two's-complement) modes and a start/done handshake.
//  Reports divide-by-zero and signed overflow as flags.
//  Sits between operand registers and the result/ALU mux in the lab datapath.
// PARAMETERS
//  N  8  operand/result width in bits (N >= 2)
// PORTS
//  clk          in   1  single system clock, rising edge
//  rst          in   1  asynchronous, active-high reset
//  start        in   1  request; sampled only in IDLE
//  signed_mode  in   1  1 = two's-complement operands, 0 = unsigned; latched with start
//  dividend     in   N  dividend; latched on accepted start
//  divisor      in   N  divisor; latched on accepted start
//  quotient     out  N  registered quotient, held until next completion
//  remainder    out  N  registered remainder, held until next completion
//  busy         out  1  high from the cycle after accept until done is asserted
//  done         out  1  one-cycle pulse: results valid
//  div_by_zero  out  1  valid with done; held until next accept
//  overflow     out  1  valid with done; held until next accept
// BEHAVIOUR
//  Reset (async): state=IDLE, quotient='0, remainder='0, busy=0, done=0, flags=0.
//  FSM IDLE -> CALC -> FIX -> IDLE; a divide-by-zero request goes IDLE -> FIX directly.
//  IDLE: on edge with start=1, latch operands and mode, clear both flags.
//   - divisor==0: set div_by_zero. Go to FIX and skip CALC.
//   - otherwise load |dividend| and |divisor|; abs is applied only if signed_mode=1.
//   - Initialise the partial remainder to 0 and the iteration counter to N-1. Go to CALC.
//  CALC: each edge, shift {R,Q} left 1, pulling the next dividend MSB into R.
//   - Compute trial = R - D using N+1 bits; if trial >= 0 then R = trial and Q[0] = 1.
//   - The counter decrements; after exactly N CALC edges, go to FIX.
//  FIX: single edge; writes quotient/remainder and pulses done.
//   - Signed mode: negate Q if the operand signs differ; the remainder takes the dividend's sign.
//     Quotient truncates toward zero.
//   - Signed overflow: dividend = -2^(N-1) and divisor = -1 -> quotient = 100..0, remainder = 0, overflow = 1.
//   - div_by_zero: quotient='0, remainder='0, matching the combinational predecessor.
//   - FIX returns to IDLE.
//  done is high for exactly the one cycle after the FIX edge.
//  Latency, start-accept edge to done high:
//   - normal: N+1 clocks.
//   - divide-by-zero: 1 clock.
//  Back-to-back: start may be high during the done cycle (FSM is in IDLE) and is accepted then.
//  start while busy: ignored; in-flight operation unaffected; inputs may change freely.
//  Reset mid-operation: abort immediately. Outputs return to reset values; no done pulse.
//  Internal R is N+1 bits for the trial subtract. Unsigned divisor up to 2^N-1 must be exact.
// TESTING (N=8)
//  T1 unsigned 200/7 -> done 9 clocks after accept; quotient=28, remainder=4; both flags 0.
//  T2 signed -7/2 (0xF9/0x02) -> quotient=0xFD (-3), remainder=0xFF (-1).
//  T3 signed 0x80/0xFF -> quotient=0x80, remainder=0x00, overflow=1.
//     The same operands unsigned (128/255) -> quotient=0, remainder=128, overflow=0.
//  T4 divisor=0, dividend=55 -> done 1 clock after accept; q=0, r=0, div_by_zero=1.
//  T5 start re-pulsed mid-CALC with new operands -> ignored; first result intact.
//     start held high in the done cycle -> second op accepted; done again 9 clocks later.
//  T6 rst asserted asynchronously in mid-CALC -> outputs clear without waiting for clk.
//     No done follows. A new 255/255 op then yields q=1, r=0.
//  All tests: compare against a reference model for 1000 random operand/mode pairs.

Source files
------------

// File: rtl/divisor_secuencial_nbit_if.sv
// Request/result bundle for the sequential N-bit divider.
// Ports (master drives request, slave drives result):
//   start, signed_mode, dividend[N], divisor[N]                   -> slave
//   quotient[N], remainder[N], busy, done, div_by_zero, overflow  -> master
interface divisor_secuencial_nbit_if #(
  parameter int N = 8
);
  logic         start;
  logic         signed_mode;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic         overflow;

  modport master (
    output start, signed_mode, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero, overflow
  );

  modport slave (
    input  start, signed_mode, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero, overflow
  );
endinterface

// File: rtl/divisor_secuencial_nbit.sv
// Restoring radix-2 divider, one quotient bit per clock, unsigned or signed.
// Latency: accept edge to done high is N+1 clocks, or 1 clock for divide-by-zero.
// Backpressure: none; start is only sampled in IDLE, ignored while busy.
// Ports: clk, rst (async, active-high), bus (slave modport):
//   in  start, signed_mode, dividend, divisor
//   out quotient, remainder (held until next completion), busy, done (1-cycle pulse),
//       div_by_zero, overflow (valid with done, held until next accept)
module divisor_secuencial_nbit #(
  parameter int N = 8
) (
  input logic                      clk,
  input logic                      rst,
  divisor_secuencial_nbit_if.slave bus
);

  localparam int           CW      = $clog2(N);
  localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N:0]    r_q, r_d;          // partial remainder, one guard bit wide
  logic [N-1:0]  q_q, q_d;          // dividend bits shifting out, quotient bits shifting in
  logic [N-1:0]  d_q, d_d;          // divisor magnitude
  logic [CW-1:0] cnt_q, cnt_d;
  logic          neg_quo_q, neg_quo_d;
  logic          neg_rem_q, neg_rem_d;
  logic          ovf_pend_q, ovf_pend_d;
  logic [N-1:0]  quotient_q, quotient_d;
  logic [N-1:0]  remainder_q, remainder_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          dz_q, dz_d;
  logic          ovf_q, ovf_d;

  logic [N:0]    r_shift;
  logic [N+1:0]  trial;
  logic [N-1:0]  a_abs, b_abs;
  logic [N-1:0]  q_fix, r_fix;

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    q_d         = q_q;
    d_d         = d_q;
    cnt_d       = cnt_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    ovf_pend_d  = ovf_pend_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    dz_d        = dz_q;
    ovf_d       = ovf_q;

    // The shifted remainder can reach 2*D-1, so the subtract carries one extra
    // bit beyond R to expose the sign even for the largest unsigned divisor.
    r_shift = {r_q[N-1:0], q_q[N-1]};
    trial   = {1'b0, r_shift} - {2'b00, d_q};

    a_abs = (bus.signed_mode && bus.dividend[N-1]) ? -bus.dividend : bus.dividend;
    b_abs = (bus.signed_mode && bus.divisor[N-1])  ? -bus.divisor  : bus.divisor;

    q_fix = neg_quo_q ? -q_q : q_q;
    r_fix = neg_rem_q ? -r_q[N-1:0] : r_q[N-1:0];

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          busy_d     = 1'b1;
          ovf_d      = 1'b0;
          dz_d       = (bus.divisor == '0);
          ovf_pend_d = bus.signed_mode && (bus.dividend == MIN_NEG) && (bus.divisor == '1);
          // Quotient sign follows the XOR of operand signs; remainder follows the dividend.
          neg_quo_d  = bus.signed_mode && (bus.dividend[N-1] ^ bus.divisor[N-1]);
          neg_rem_d  = bus.signed_mode && bus.dividend[N-1];
          if (bus.divisor == '0) begin
            state_d = FIX;
          end else begin
            q_d     = a_abs;
            d_d     = b_abs;
            r_d     = '0;
            cnt_d   = CW'(N - 1);
            state_d = CALC;
          end
        end
      end

      CALC: begin
        if (!trial[N+1]) begin
          r_d = trial[N:0];
          q_d = {q_q[N-2:0], 1'b1};
        end else begin
          r_d = r_shift;
          q_d = {q_q[N-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = FIX;
        end
      end

      FIX: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (dz_q) begin
          quotient_d  = '0;
          remainder_d = '0;
        end else if (ovf_pend_q) begin
          quotient_d  = MIN_NEG;
          remainder_d = '0;
          ovf_d       = 1'b1;
        end else begin
          quotient_d  = q_fix;
          remainder_d = r_fix;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      ovf_pend_q  <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dz_q        <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      q_q         <= q_d;
      d_q         <= d_d;
      cnt_q       <= cnt_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      ovf_pend_q  <= ovf_pend_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dz_q        <= dz_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dz_q;
  assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_divisor_secuencial_nbit.sv
// Directed and random checks of the sequential divider at N=8.
module tb_divisor_secuencial_nbit;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  divisor_secuencial_nbit_if #(.N(N)) bus ();

  divisor_secuencial_nbit #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents a request and returns 1ns after the accepting edge.
  task automatic go(input logic [N-1:0] a, input logic [N-1:0] b, input logic sm);
    @(negedge clk);
    bus.start       = 1'b1;
    bus.dividend    = a;
    bus.divisor     = b;
    bus.signed_mode = sm;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Counts edges until done is seen high; -1 means it never came.
  task automatic wait_done(output int lat);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      #1;
      lat++;
      seen = bus.done;
    end
    if (!seen) lat = -1;
  endtask

  task automatic op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                    input logic sm, input logic [N-1:0] eq, input logic [N-1:0] er,
                    input logic edz, input logic eov, input int elat);
    int lat;
    go(a, b, sm);
    chk($sformatf("%s_busy", tag), {31'd0, bus.busy}, 32'd1);
    wait_done(lat);
    chk($sformatf("%s_lat", tag), lat, elat);
    chk($sformatf("%s_q", tag), {24'd0, bus.quotient}, {24'd0, eq});
    chk($sformatf("%s_r", tag), {24'd0, bus.remainder}, {24'd0, er});
    chk($sformatf("%s_dz", tag), {31'd0, bus.div_by_zero}, {31'd0, edz});
    chk($sformatf("%s_ov", tag), {31'd0, bus.overflow}, {31'd0, eov});
    chk($sformatf("%s_idle", tag), {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic model(input logic [N-1:0] a, input logic [N-1:0] b, input logic sm,
                       output logic [N-1:0] q, output logic [N-1:0] r,
                       output logic dz, output logic ov);
    int sa, sb;
    dz = 1'b0;
    ov = 1'b0;
    if (b == 0) begin
      q  = '0;
      r  = '0;
      dz = 1'b1;
    end else if (!sm) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = {{24{a[7]}}, a};
      sb = {{24{b[7]}}, b};
      if (sa == -128 && sb == -1) begin
        q  = 8'h80;
        r  = 8'h00;
        ov = 1'b1;
      end else begin
        q = 8'(sa / sb);
        r = 8'(sa % sb);
      end
    end
  endtask

  initial begin
    int          lat;
    int          dn;
    logic [N-1:0] ra, rb, mq, mr;
    logic        rsm, mdz, mov;

    rst             = 1'b1;
    bus.start       = 1'b0;
    bus.signed_mode = 1'b0;
    bus.dividend    = '0;
    bus.divisor     = '0;
    repeat (2) @(negedge clk);
    chk("rst_q",    {24'd0, bus.quotient},  32'd0);
    chk("rst_r",    {24'd0, bus.remainder}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy},      32'd0);
    chk("rst_done", {31'd0, bus.done},      32'd0);
    chk("rst_dz",   {31'd0, bus.div_by_zero}, 32'd0);
    chk("rst_ov",   {31'd0, bus.overflow},  32'd0);
    rst = 1'b0;

    // T1..T4
    op("t1_u200_7",   8'd200, 8'd7,   1'b0, 8'd28,  8'd4,   1'b0, 1'b0, 9);
    op("t2_sm7_2",    8'hF9,  8'h02,  1'b1, 8'hFD,  8'hFF,  1'b0, 1'b0, 9);
    op("t3_s_ovf",    8'h80,  8'hFF,  1'b1, 8'h80,  8'h00,  1'b0, 1'b1, 9);
    op("t3_u128_255", 8'h80,  8'hFF,  1'b0, 8'h00,  8'd128, 1'b0, 1'b0, 9);
    op("t4_dz",       8'd55,  8'd0,   1'b0, 8'h00,  8'h00,  1'b1, 1'b0, 1);
    op("u255_1",      8'd255, 8'd1,   1'b0, 8'd255, 8'd0,   1'b0, 1'b0, 9);
    op("s7_m2",       8'd7,   8'hFE,  1'b1, 8'hFD,  8'd1,   1'b0, 1'b0, 9);
    op("u3_250",      8'd3,   8'd250, 1'b0, 8'd0,   8'd3,   1'b0, 1'b0, 9);

    // T5: re-pulse start mid-CALC, then chain a request in the done cycle
    go(8'd200, 8'd7, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    bus.start    = 1'b1;
    bus.dividend = 8'd9;
    bus.divisor  = 8'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(lat);
    chk("t5_lat", lat, 5);
    chk("t5_q", {24'd0, bus.quotient},  32'd28);
    chk("t5_r", {24'd0, bus.remainder}, 32'd4);
    bus.start    = 1'b1;
    bus.dividend = 8'd100;
    bus.divisor  = 8'd9;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("t5b_busy", {31'd0, bus.busy}, 32'd1);
    wait_done(lat);
    chk("t5b_lat", lat, 9);
    chk("t5b_q", {24'd0, bus.quotient},  32'd11);
    chk("t5b_r", {24'd0, bus.remainder}, 32'd1);

    // T6: asynchronous reset mid-CALC
    go(8'd200, 8'd7, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("t6_q",    {24'd0, bus.quotient},  32'd0);
    chk("t6_r",    {24'd0, bus.remainder}, 32'd0);
    chk("t6_busy", {31'd0, bus.busy},      32'd0);
    chk("t6_done", {31'd0, bus.done},      32'd0);
    @(negedge clk);
    rst = 1'b0;
    dn  = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      dn += int'(bus.done);
    end
    chk("t6_no_done", dn, 0);
    op("t6_255_255", 8'd255, 8'd255, 1'b0, 8'd1, 8'd0, 1'b0, 1'b0, 9);

    // Random sweep against the reference model
    for (int i = 0; i < 1000; i++) begin
      ra  = 8'($urandom);
      rb  = (i % 50 == 7) ? 8'd0 : 8'($urandom);
      rsm = 1'($urandom);
      if (i % 97 == 3) begin
        ra  = 8'h80;
        rb  = 8'hFF;
      end
      model(ra, rb, rsm, mq, mr, mdz, mov);
      op($sformatf("rnd%0d", i), ra, rb, rsm, mq, mr, mdz, mov, (rb == 0) ? 1 : 9);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
